sysid_checker: RTL and testbench

SYSID_CHECKER -- requirements
Module: sysid_checker

---
 rtl/sysid_checker_pkg.sv | 18 +
 rtl/sysid_checker_timer.sv | 31 +++
 rtl/sysid_checker.sv | 186 ++++++++++++++++++
 tb/tb_sysid_checker.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the sysid checker.
package sysid_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_ID = 3'd1,
        ST_RD_TS = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    // Wait-state counter width.
    localparam int CNT_W = 16;

endpackage

// File: rtl/sysid_checker_timer.sv
// Wait-state counter: counts stall cycles, saturates at all-ones, and flags
// the stall cycle that brings the count up to the limit.
module sysid_checker_timer
    import sysid_checker_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W:0]   w_count_inc;

    assign w_count_inc = {1'b0, r_count} + {{CNT_W{1'b0}}, 1'b1};

    // The current stall is the limit-th one, so the read gives up this cycle.
    assign expired = enable && (w_count_inc >= {1'b0, limit});

    // Count stall cycles; clear has priority so each read starts from zero.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable && (r_count != {CNT_W{1'b1}})) begin
            r_count <= w_count_inc[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/sysid_checker.sv
// Reads the sysid ID and timestamp words over Avalon-MM and compares them
// against the expected build values.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   ST_IDLE  | waiting for start (or the one-shot auto start)
//   ST_RD_ID | read strobe on address 0, capture ID word
//   ST_RD_TS | read strobe on address 1, capture timestamp word
//   ST_CHECK | register the compare results
//   ST_DONE  | report finished for one cycle, then back to idle
module sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXP_ID         = 32'h0000_0000,
    parameter logic [31:0] EXP_TS         = 32'h6603_8F82,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          AUTO_START     = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        m_address,
    output logic        m_read,
    input  logic [31:0] m_readdata,
    input  logic        m_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_auto_pend;
    logic        r_busy;
    logic        r_done;
    logic        r_id_ok;
    logic        r_ts_ok;
    logic        r_timeout;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;

    logic        w_rd_active;
    logic        w_stall;
    logic        w_expired;
    logic        w_tmr_clear;
    logic        w_start_chk;
    logic        w_cap_id;
    logic        w_cap_ts;
    logic        w_do_check;
    logic        w_abort;
    logic        w_enter_done;

    assign w_rd_active = (r_state == ST_RD_ID) || (r_state == ST_RD_TS);
    assign w_stall     = w_rd_active && m_waitrequest;
    // Zero the counter outside reads and on every state change, so each read
    // state is entered with a fresh count.
    assign w_tmr_clear = !w_rd_active || (w_next_state != r_state);

    sysid_checker_timer u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (w_tmr_clear),
        .enable  (w_stall),
        .limit   (LIMIT),
        .expired (w_expired)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and bus strobes; strobes depend only on state so they
    // hold steady across wait states.
    always_comb begin
        w_next_state = r_state;
        w_start_chk  = 1'b0;
        w_cap_id     = 1'b0;
        w_cap_ts     = 1'b0;
        w_do_check   = 1'b0;
        w_abort      = 1'b0;
        m_read       = 1'b0;
        m_address    = ADDR_ID;
        case (r_state)
            ST_IDLE: begin
                if (start || r_auto_pend) begin
                    w_start_chk  = 1'b1;
                    w_next_state = ST_RD_ID;
                end
            end
            ST_RD_ID: begin
                m_read    = 1'b1;
                m_address = ADDR_ID;
                if (!m_waitrequest) begin
                    w_cap_id     = 1'b1;
                    w_next_state = ST_RD_TS;
                end else if (w_expired) begin
                    w_abort      = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_RD_TS: begin
                m_read    = 1'b1;
                m_address = ADDR_TS;
                if (!m_waitrequest) begin
                    w_cap_ts     = 1'b1;
                    w_next_state = ST_CHECK;
                end else if (w_expired) begin
                    w_abort      = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_CHECK: begin
                w_do_check   = 1'b1;
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_enter_done = (w_next_state == ST_DONE) && (r_state != ST_DONE);

    // Status flags and captured words; all hold until the next check starts.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_auto_pend <= (AUTO_START != 0);
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_id_ok     <= 1'b0;
            r_ts_ok     <= 1'b0;
            r_timeout   <= 1'b0;
            r_id_value  <= '0;
            r_ts_value  <= '0;
        end else begin
            if (w_start_chk) begin
                r_auto_pend <= 1'b0;
                r_busy      <= 1'b1;
                r_done      <= 1'b0;
                r_id_ok     <= 1'b0;
                r_ts_ok     <= 1'b0;
                r_timeout   <= 1'b0;
            end
            if (w_cap_id) begin
                r_id_value <= m_readdata;
            end
            if (w_cap_ts) begin
                r_ts_value <= m_readdata;
            end
            if (w_do_check) begin
                r_id_ok <= (r_id_value == EXP_ID);
                r_ts_ok <= (r_ts_value == EXP_TS);
            end
            if (w_abort) begin
                r_timeout <= 1'b1;
            end
            if (w_enter_done) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign id_ok    = r_id_ok;
    assign ts_ok    = r_ts_ok;
    assign timeout  = r_timeout;
    assign id_value = r_id_value;
    assign ts_value = r_ts_value;

endmodule

// File: tb/tb_sysid_checker.sv
// Testbench for sysid_checker: a cycle-stepped slave plus a read-window model
// of the expected bus activity and results.
module tb_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'h6603_8F82;
    localparam int          TMO    = 4;

    logic        clock;
    logic        reset;
    logic        start;
    logic        m_address;
    logic        m_read;
    logic [31:0] m_readdata;
    logic        m_waitrequest;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    int          n_checks;
    int          n_fail;
    logic [31:0] m_id;
    logic [31:0] m_ts;

    sysid_checker #(
        .EXP_ID         (EXP_ID),
        .EXP_TS         (EXP_TS),
        .TIMEOUT_CYCLES (TMO),
        .AUTO_START     (1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .m_address     (m_address),
        .m_read        (m_read),
        .m_readdata    (m_readdata),
        .m_waitrequest (m_waitrequest),
        .busy          (busy),
        .done          (done),
        .id_ok         (id_ok),
        .ts_ok         (ts_ok),
        .timeout       (timeout),
        .id_value      (id_value),
        .ts_value      (ts_value)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One full check. Iteration j samples outputs at the negedge before edge
    // N+j, where edge N samples the start (or the first edge out of reset).
    // sid/sts: stall cycles the slave inserts on the ID / timestamp read.
    // inj: iteration at which an extra start pulse is driven (0 = none).
    task automatic run_check(input bit auto_mode, input int sid, input int sts,
                             input logic [31:0] id_d, input logic [31:0] ts_d,
                             input int inj);
        int          id_len, ts_len, done_j, inj_j, cnt, stall;
        bit          to, exp_read, exp_addr, e_idok, e_tsok, prev_rd, prev_addr, wr;
        logic [31:0] e_id, e_ts;

        if (sid >= TMO) begin
            id_len = TMO; ts_len = 0; to = 1'b1;
        end else begin
            id_len = sid + 1;
            if (sts >= TMO) begin ts_len = TMO; to = 1'b1; end
            else begin ts_len = sts + 1; to = 1'b0; end
        end
        done_j = id_len + ts_len + (to ? 1 : 2);
        e_id   = (sid >= TMO) ? m_id : id_d;
        e_ts   = to ? m_ts : ts_d;
        e_idok = !to && (id_d == EXP_ID);
        e_tsok = !to && (ts_d == EXP_TS);
        inj_j  = (inj > done_j) ? 0 : inj;

        @(negedge clock);
        if (auto_mode) begin reset = 1'b0; start = 1'b0; end
        else start = 1'b1;
        m_waitrequest = 1'b0;
        prev_rd = 1'b0; prev_addr = 1'b0; cnt = 0;

        for (int j = 1; j <= done_j + 2; j++) begin
            @(negedge clock);
            start = (j == inj_j);
            exp_read = (j <= id_len + ts_len);
            exp_addr = exp_read && (j > id_len);

            n_checks++;
            if (m_read !== exp_read) begin
                n_fail++; $display("FAIL m_read j=%0d: got %b expected %b", j, m_read, exp_read);
            end
            if (exp_read) begin
                n_checks++;
                if (m_address !== exp_addr) begin
                    n_fail++; $display("FAIL m_address j=%0d: got %b expected %b", j, m_address, exp_addr);
                end
            end
            n_checks++;
            if (busy !== (j < done_j)) begin
                n_fail++; $display("FAIL busy j=%0d: got %b expected %b", j, busy, (j < done_j));
            end
            n_checks++;
            if (done !== (j >= done_j)) begin
                n_fail++; $display("FAIL done j=%0d: got %b expected %b", j, done, (j >= done_j));
            end
            if (j == 1) begin
                n_checks++;
                if ({id_ok, ts_ok, timeout} !== 3'b000) begin
                    n_fail++; $display("FAIL flags_clear: got %b expected 000", {id_ok, ts_ok, timeout});
                end
            end
            if (j >= done_j) begin
                n_checks++;
                if ({id_ok, ts_ok, timeout} !== {e_idok, e_tsok, to}) begin
                    n_fail++; $display("FAIL flags j=%0d: got %b expected %b", j,
                                       {id_ok, ts_ok, timeout}, {e_idok, e_tsok, to});
                end
                n_checks++;
                if ({id_value, ts_value} !== {e_id, e_ts}) begin
                    n_fail++; $display("FAIL values j=%0d: got %h/%h expected %h/%h", j,
                                       id_value, ts_value, e_id, e_ts);
                end
            end

            // Slave: stall the first N cycles of each read, then return data.
            if (m_read === 1'b1) begin
                if (prev_rd && (m_address == prev_addr)) cnt++;
                else cnt = 1;
                stall = m_address ? sts : sid;
                wr = (cnt <= stall);
                m_waitrequest = wr;
                m_readdata = wr ? $urandom : (m_address ? ts_d : id_d);
                prev_rd = 1'b1; prev_addr = m_address;
            end else begin
                cnt = 0; prev_rd = 1'b0;
                m_waitrequest = 1'b0;
                m_readdata = $urandom;
            end
        end
        start = 1'b0;
        m_waitrequest = 1'b0;
        m_id = e_id;
        m_ts = e_ts;
    endtask

    task automatic test_reset();
        logic [70:0] outs;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        outs = {m_read, m_address, busy, done, id_ok, ts_ok, timeout, id_value, ts_value};
        n_checks++;
        if (outs !== '0) begin
            n_fail++; $display("FAIL reset_state: got %h expected 0", outs);
        end
        m_id = '0; m_ts = '0;
        // Auto start after reset release, zero wait states, matching words.
        run_check(1'b1, 0, 0, EXP_ID, EXP_TS, 0);
    endtask

    task automatic test_bad_ts();
        run_check(1'b0, 0, 0, EXP_ID, 32'h6603_8F83, 0);
        run_check(1'b0, 0, 0, 32'hDEAD_0001, EXP_TS, 0);
    endtask

    task automatic test_wait_states();
        run_check(1'b0, 3, 3, EXP_ID, EXP_TS, 0);
        run_check(1'b0, 1, 2, EXP_ID, EXP_TS, 0);
    endtask

    task automatic test_timeout();
        run_check(1'b0, 1000, 0, EXP_ID, EXP_TS, 0);
        run_check(1'b0, 1, 1000, 32'h0000_1234, EXP_TS, 0);
        run_check(1'b0, TMO - 1, TMO - 1, EXP_ID, EXP_TS, 0);
    endtask

    task automatic test_back_to_back();
        // Extra start during RD_TS (j=3), then extra start while in DONE.
        run_check(1'b0, 0, 2, EXP_ID, EXP_TS, 3);
        run_check(1'b0, 0, 0, EXP_ID, EXP_TS, 4);
        run_check(1'b0, 0, 0, EXP_ID, EXP_TS, 0);
    endtask

    task automatic test_reset_mid_read();
        logic [70:0] outs;
        @(negedge clock);
        start = 1'b1;
        m_waitrequest = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n_checks++;
        if ({m_read, m_address, busy} !== 3'b101) begin
            n_fail++; $display("FAIL mid_read_setup: got %b expected 101", {m_read, m_address, busy});
        end
        reset = 1'b1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        outs = {m_read, m_address, busy, done, id_ok, ts_ok, timeout, id_value, ts_value};
        n_checks++;
        if (outs !== '0) begin
            n_fail++; $display("FAIL reset_abort: got %h expected 0", outs);
        end
        @(negedge clock);
        outs = {m_read, m_address, busy, done, id_ok, ts_ok, timeout, id_value, ts_value};
        n_checks++;
        if (outs !== '0) begin
            n_fail++; $display("FAIL reset_hold: got %h expected 0", outs);
        end
        m_waitrequest = 1'b0;
        m_id = '0; m_ts = '0;
        run_check(1'b1, 1, 1, EXP_ID, EXP_TS, 0);
    endtask

    task automatic test_random();
        int          sid, sts, inj;
        logic [31:0] id_d, ts_d;
        for (int k = 0; k < 24; k++) begin
            sid  = $urandom_range(0, 5);
            sts  = $urandom_range(0, 5);
            id_d = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
            ts_d = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
            inj  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 12);
            run_check(1'b0, sid, sts, id_d, ts_d, inj);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        start         = 1'b0;
        m_waitrequest = 1'b0;
        m_readdata    = '0;
        m_id          = '0;
        m_ts          = '0;
        test_reset();
        test_bad_ts();
        test_wait_states();
        test_timeout();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
